// File: rtl/sys_reset_seq.sv
// sys_reset_seq: staged reset sequencer (clk, rst, ext_rst_n_i buttons, pll_locked_i, dbg_rst_i in; rst_o stages, seq_done_o, rst_cause_o out)
module sys_reset_seq #(
  parameter int NUM_EXT   = 2,
  parameter int NUM_STAGE = 3,
  parameter int DEBOUNCE  = 16,
  parameter int HOLD      = 16,
  parameter int GAP       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_EXT-1:0]   ext_rst_n_i,
  input  logic                 pll_locked_i,
  input  logic                 dbg_rst_i,
  output logic [NUM_STAGE-1:0] rst_o,
  output logic                 seq_done_o,
  output logic [1:0]           rst_cause_o
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP);
  localparam logic [NUM_STAGE-1:0] ALL = '1;
  typedef enum logic [1:0] {S_ASSERT, S_RELEASE, S_RUN} state_t;
  state_t state_q, state_d;
  logic [NUM_EXT-1:0] ext_s1_q, ext_s2_q, db_val_q, db_val_d;
  logic [DW-1:0] db_cnt_q [NUM_EXT];
  logic [DW-1:0] db_cnt_d [NUM_EXT];
  logic lock_s1_q, lock_s2_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [NUM_STAGE-1:0] rst_q, rst_d;
  logic done_q, done_d;
  logic [1:0] cause_q, cause_d;
  logic src_ext, src_lock, src_any;
  assign src_ext = ~&db_val_q;
  assign src_lock = ~lock_s2_q;
  assign src_any = src_ext | src_lock | dbg_rst_i;
  assign rst_o = rst_q;
  assign seq_done_o = done_q;
  assign rst_cause_o = cause_q;
  always_comb begin
    db_val_d = db_val_q;
    for (int i = 0; i < NUM_EXT; i++) begin
      db_cnt_d[i] = (ext_s2_q[i] == db_val_q[i] || db_cnt_q[i] == DB_LAST) ? '0 : db_cnt_q[i] + 1'b1;
      if (ext_s2_q[i] != db_val_q[i] && db_cnt_q[i] == DB_LAST) db_val_d[i] = ext_s2_q[i];
    end
  end
  // Stages release lowest-first, so each release is a left shift of the
  // remaining-asserted mask; an all-zero mask means the sequence is complete.
  always_comb begin
    state_d = state_q;
    hold_d = '0;
    gap_d = '0;
    rst_d = rst_q;
    done_d = done_q;
    cause_d = cause_q;
    if (state_q == S_ASSERT) begin
      rst_d = ALL;
      done_d = 1'b0;
      hold_d = src_any ? '0 : (hold_q == HOLD_MAX ? hold_q : hold_q + 1'b1);
      if (!src_any && hold_q >= HOLD_LAST) begin
        hold_d = '0;
        rst_d = ALL << 1;
        done_d = ~|rst_d;
        state_d = done_d ? S_RUN : S_RELEASE;
      end
    end else if (src_any) begin
      state_d = S_ASSERT;
      rst_d = ALL;
      done_d = 1'b0;
      cause_d = src_lock ? 2'd2 : src_ext ? 2'd1 : 2'd3;
    end else if (state_q == S_RELEASE) begin
      gap_d = gap_q == GAP_MAX ? '0 : gap_q + 1'b1;
      if (gap_q == GAP_MAX) begin
        rst_d = rst_q << 1;
        done_d = ~|rst_d;
        state_d = done_d ? S_RUN : S_RELEASE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_s1_q <= '1;
      ext_s2_q <= '1;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      db_val_q <= '1;
      db_cnt_q <= '{default: '0};
      state_q <= S_ASSERT;
      hold_q <= '0;
      gap_q <= '0;
      rst_q <= ALL;
      done_q <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      ext_s1_q <= ext_rst_n_i;
      ext_s2_q <= ext_s1_q;
      lock_s1_q <= pll_locked_i;
      lock_s2_q <= lock_s1_q;
      db_val_q <= db_val_d;
      db_cnt_q <= db_cnt_d;
      state_q <= state_d;
      hold_q <= hold_d;
      gap_q <= gap_d;
      rst_q <= rst_d;
      done_q <= done_d;
      cause_q <= cause_d;
    end
  end
endmodule

// File: tb/tb_sys_reset_seq.sv
// tb_sys_reset_seq: randomized and directed checks of sys_reset_seq against a time-based reference model
module tb_sys_reset_seq;
  localparam int NE = 2, NS = 3, DB = 16, HD = 16, GP = 4;
  localparam int T0 = 2 + HD, T1 = T0 + GP + 1, T2 = T1 + GP + 1, TB = 2 + DB + 1;
  logic clk = 1'b0, rst = 1'b1, lock = 1'b1, dbg = 1'b0;
  logic [NE-1:0] ext = '1;
  logic [NS-1:0] rst_o;
  logic seq_done_o, done1;
  logic [1:0] cause, cause1;
  logic [0:0] rst1_o;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  sys_reset_seq #(.NUM_EXT(NE), .NUM_STAGE(NS), .DEBOUNCE(DB), .HOLD(HD), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .ext_rst_n_i(ext), .pll_locked_i(lock), .dbg_rst_i(dbg),
    .rst_o(rst_o), .seq_done_o(seq_done_o), .rst_cause_o(cause));
  sys_reset_seq #(.NUM_EXT(NE), .NUM_STAGE(1), .DEBOUNCE(DB), .HOLD(HD), .GAP(GP)) dut1 (
    .clk(clk), .rst(rst), .ext_rst_n_i(ext), .pll_locked_i(lock), .dbg_rst_i(dbg),
    .rst_o(rst1_o), .seq_done_o(done1), .rst_cause_o(cause1));
  // Reference model: inputs seen through a 2-sample delay, buttons change after
  // DB consecutive differing samples, release time measured from the release start.
  bit [NE-1:0] m_e1, m_e2, m_db;
  int m_run [NE];
  bit m_l1, m_l2, m_rel;
  int m_q, m_t;
  logic [1:0] m_cause = 2'd0;
  always @(posedge clk) begin
    bit s_ext, s_lock, s_any;
    if (rst) begin
      m_e1 = '1; m_e2 = '1; m_db = '1; m_l1 = 0; m_l2 = 0;
      m_rel = 0; m_q = 0; m_t = 0; m_cause = 2'd0;
      for (int i = 0; i < NE; i++) m_run[i] = 0;
    end else begin
      s_ext = m_db != '1;
      s_lock = !m_l2;
      s_any = s_ext || s_lock || dbg;
      if (!m_rel) begin
        m_q = s_any ? 0 : m_q + 1;
        if (m_q >= HD) begin m_rel = 1; m_t = 0; end
      end else if (s_any) begin
        m_rel = 0; m_q = 0;
        m_cause = s_lock ? 2'd2 : s_ext ? 2'd1 : 2'd3;
      end else if (m_t < 100000) m_t++;
      for (int i = 0; i < NE; i++) begin
        if (m_e2[i] == m_db[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB) begin m_db[i] = m_e2[i]; m_run[i] = 0; end
        end
      end
      m_e2 = m_e1; m_e1 = ext; m_l2 = m_l1; m_l1 = lock;
    end
  end
  logic [NS-1:0] exp_rst;
  logic exp_done;
  always_comb begin
    for (int k = 0; k < NS; k++) exp_rst[k] = !(m_rel && m_t >= k * (GP + 1));
    exp_done = m_rel && m_t >= (NS - 1) * (GP + 1);
  end
  wire [9:0] obs = {rst_o, seq_done_o, cause, rst1_o, done1, cause1};
  wire [9:0] expv = {exp_rst, exp_done, m_cause, !m_rel, m_rel, m_cause};
  task automatic test_reset();
    rst = 1; lock = 1; ext = '1; dbg = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== {3'b111, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL reset got=%b exp=%b", obs, {3'b111, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0}); end
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_model got=%b exp=%b", obs, expv); end
    end
  endtask
  task automatic test_powerup();
    logic [9:0] c;
    lock = 1; ext = '1; dbg = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    for (int n = 1; n <= T2 + 5; n++) begin
      @(negedge clk);
      c = {n < T2, n < T1, n < T0, n >= T2, 2'd0, n < T0, n >= T0, 2'd0};
      checks++;
      if (obs !== c) begin errors++; $display("FAIL powerup cyc=%0d got=%b exp=%b", n, obs, c); end
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL powerup_model cyc=%0d got=%b exp=%b", n, obs, expv); end
    end
  endtask
  task automatic test_glitch();
    ext[1] = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 10) ext[1] = 1;
      checks++;
      if (obs !== {3'b000, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL glitch cyc=%0d got=%b exp=%b", n, obs, {3'b000, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0}); end
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL glitch_model cyc=%0d got=%b exp=%b", n, obs, expv); end
    end
    ext[1] = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      checks++;
      if (n < TB && (rst_o !== 3'b000 || cause !== 2'd0)) begin errors++; $display("FAIL press_early cyc=%0d rst_o=%b cause=%0d exp 000/0", n, rst_o, cause); end
      else if (n >= TB && (rst_o !== 3'b111 || cause !== 2'd1 || seq_done_o !== 1'b0)) begin errors++; $display("FAIL press_assert cyc=%0d rst_o=%b cause=%0d done=%b exp 111/1/0", n, rst_o, cause, seq_done_o); end
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL press_model cyc=%0d got=%b exp=%b", n, obs, expv); end
    end
    ext[1] = 1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 2 + DB + HD - 1 || n == 2 + DB + HD) begin
        checks++;
        if (rst_o !== (n == 2 + DB + HD ? 3'b110 : 3'b111)) begin errors++; $display("FAIL btn_restart cyc=%0d rst_o=%b exp=%b", n, rst_o, (n == 2 + DB + HD ? 3'b110 : 3'b111)); end
      end
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL btn_restart_model cyc=%0d got=%b exp=%b", n, obs, expv); end
    end
    checks++;
    if (seq_done_o !== 1'b1) begin errors++; $display("FAIL btn_done got=%b exp=1", seq_done_o); end
  endtask
  task automatic test_lock_loss();
    int w = 0;
    dbg = 1;
    @(negedge clk);
    dbg = 0;
    while (rst_o !== 3'b110 && w < 100) begin
      @(negedge clk);
      w++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL lock_wait_model got=%b exp=%b", obs, expv); end
    end
    checks++;
    if (rst_o !== 3'b110) begin errors++; $display("FAIL lock_wait_timeout rst_o=%b exp=110", rst_o); end
    lock = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n >= 3) begin
        checks++;
        if (rst_o !== 3'b111 || seq_done_o !== 1'b0 || cause !== 2'd2) begin errors++; $display("FAIL lock_loss cyc=%0d rst_o=%b done=%b cause=%0d exp 111/0/2", n, rst_o, seq_done_o, cause); end
      end
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL lock_model cyc=%0d got=%b exp=%b", n, obs, expv); end
    end
    lock = 1;
    w = 0;
    while (seq_done_o !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL lock_restore_model got=%b exp=%b", obs, expv); end
    end
    checks++;
    if (seq_done_o !== 1'b1) begin errors++; $display("FAIL lock_restore_timeout done=%b exp=1", seq_done_o); end
  endtask
  task automatic test_dbg();
    int w = 0;
    lock = 0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL dbg_lock_model cyc=%0d got=%b exp=%b", n, obs, expv); end
      if (n == 2) dbg = 1;
    end
    checks++;
    if (cause !== 2'd2 || rst_o !== 3'b111) begin errors++; $display("FAIL dbg_lock_prio cause=%0d rst_o=%b exp 2/111", cause, rst_o); end
    dbg = 0; lock = 1;
    while (seq_done_o !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL dbg_wait_model got=%b exp=%b", obs, expv); end
    end
    checks++;
    if (seq_done_o !== 1'b1) begin errors++; $display("FAIL dbg_wait_timeout done=%b exp=1", seq_done_o); end
    dbg = 1;
    for (int n = 1; n <= T2; n++) begin
      @(negedge clk);
      if (n == 1) begin
        dbg = 0;
        checks++;
        if (rst_o !== 3'b111 || cause !== 2'd3 || seq_done_o !== 1'b0) begin errors++; $display("FAIL dbg_pulse rst_o=%b cause=%0d done=%b exp 111/3/0", rst_o, cause, seq_done_o); end
      end
      if (n == HD || n == HD + 1) begin
        checks++;
        if (rst_o !== (n == HD ? 3'b111 : 3'b110)) begin errors++; $display("FAIL dbg_release cyc=%0d rst_o=%b exp=%b", n, rst_o, (n == HD ? 3'b111 : 3'b110)); end
      end
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL dbg_model cyc=%0d got=%b exp=%b", n, obs, expv); end
    end
    checks++;
    if (seq_done_o !== 1'b1 || cause !== 2'd3) begin errors++; $display("FAIL dbg_done done=%b cause=%0d exp 1/3", seq_done_o, cause); end
  endtask
  task automatic test_rst_mid();
    checks++;
    if (cause !== 2'd3) begin errors++; $display("FAIL rst_mid_pre cause=%0d exp=3", cause); end
    test_powerup();
  endtask
  task automatic test_random();
    int kind, len, gap, b;
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 5);
      len = $urandom_range(1, 40);
      gap = $urandom_range(0, 70);
      b = $urandom_range(0, NE - 1);
      case (kind)
        1: begin lock = 0; len = $urandom_range(1, 8); end
        2: ext[b] = 0;
        3: begin dbg = 1; len = $urandom_range(1, 3); end
        4: begin rst = 1; len = $urandom_range(1, 2); end
        default: ;
      endcase
      for (int c = 0; c < len + gap; c++) begin
        @(negedge clk);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL random seg=%0d kind=%0d cyc=%0d got=%b exp=%b", s, kind, c, obs, expv); end
        if (kind == 5 && c < len) ext = NE'($urandom);
        if (c == len - 1) begin lock = 1; ext = '1; dbg = 0; rst = 0; end
      end
    end
  endtask
  initial begin
    test_reset();
    test_powerup();
    test_glitch();
    test_lock_loss();
    test_dbg();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sys_reset_seq.md
# sys_reset_seq

Parametrised board-level reset sequencer for the FPGA system top. It replaces the fixed combination of the active-low reset buttons, PLL lock and the vendor reset IP. It synchronises and debounces any number of external reset buttons, monitors PLL/MMCM lock, and accepts a debug system-reset request. It then releases a configurable number of active-high reset domains in a staged order (e.g. interconnect, peripherals, core) and reports the cause of the last reset.

## Interface
Parameters:
- NUM_EXT, 2, number of external active-low reset buttons (≥1)
- NUM_STAGE, 3, number of staged reset outputs (≥1)
- DEBOUNCE, 16, consecutive stable synchronised samples required to change a debounced button value (≥1)
- HOLD, 16, minimum consecutive cycles with no reset source active before release starts (≥1)
- GAP, 4, cycles between successive stage releases (≥1)

Ports:
- clk  in  1  system clock (the 16 MHz MMCM output in the standard build)
- rst  in  1  synchronous, active-high global reset
- ext_rst_n_i  in  NUM_EXT  asynchronous active-low reset buttons
- pll_locked_i  in  1  asynchronous clock-generator lock indicator
- dbg_rst_i  in  1  synchronous active-high debug system-reset request (level)
- rst_o  out  NUM_STAGE  active-high domain resets; bit 0 releases first
- seq_done_o  out  1  high when all stages are released
- rst_cause_o  out  2  cause of the last entry to ASSERT: 0 = power-on/rst, 1 = external button, 2 = lock loss, 3 = debug

## Operation
- Synchronisers: each ext_rst_n_i bit passes through a 2-flop synchroniser with reset value 1. pll_locked_i passes through a 2-flop synchroniser with reset value 0.
- Debounce, per button:
  - A counter of width $clog2(DEBOUNCE+1) clears whenever the synchronised sample equals the debounced value.
  - Otherwise it increments. When it reaches DEBOUNCE, the debounced value takes the sample and the counter clears.
  - Reset value of the debounced value is 1. Press and release are debounced symmetrically.
- Sources: src_ext = any debounced button low; src_lock = synchronised lock low; src_dbg = dbg_rst_i; src_any = OR of all three.
- State machine, with states ASSERT, RELEASE, RUN:
  - ASSERT: all rst_o = 1, seq_done_o = 0. The hold counter clears on any cycle with src_any = 1 and otherwise increments. On the cycle the hold counter reaches HOLD with src_any = 0, go to RELEASE: clear rst_o[0], clear the gap counter, set stage index to 1.
  - RELEASE: the gap counter increments each cycle. When it reaches GAP, clear rst_o[stage index], increment the index and clear the gap counter. When the final stage is cleared, go to RUN and set seq_done_o = 1 on the same edge. If NUM_STAGE = 1, ASSERT goes directly to RUN, with rst_o[0] = 0 and seq_done_o = 1 on the same edge.
  - RUN: hold outputs.
  - From RELEASE or RUN: src_any = 1 means next state ASSERT, with all rst_o = 1 and seq_done_o = 0 on the next edge. This aborts a release in progress and clears all counters.
- Cause capture: rst_cause_o is loaded on each RELEASE/RUN → ASSERT transition. Priority when sources coincide: lock loss (2) > external (1) > debug (3). Sources active while already in ASSERT do not change rst_cause_o.
- rst = 1: state ASSERT, all counters 0, rst_o all 1, seq_done_o = 0, rst_cause_o = 0, debounced values 1, synchroniser flops at their reset values. rst asserted mid-sequence has the same effect on the next edge.

## Timing
- Outputs are all registered; there is no combinational path from inputs to outputs.
- Lock or button latency to the synchronised value: 2 cycles. A button adds DEBOUNCE cycles on top.
- From the first cycle in ASSERT with src_any = 0, rst_o[0] falls after HOLD cycles.
- rst_o[k] falls GAP+1 cycles after rst_o[k-1] (one gap-counter clear cycle plus GAP counts).
- The source-to-assert reaction in RELEASE/RUN is 1 cycle after the source is visible internally.
- Counter widths are $clog2(max+1). No counter wraps; each saturates at its terminal value until cleared.

## Test plan
- Power-up (NUM_STAGE = 3, HOLD = 16, GAP = 4), pll_locked_i = 1 and buttons high from time 0, rst released at cycle 0 → rst_o[0] falls at cycle 2 + 16; rst_o[1] falls GAP+1 later; rst_o[2] and seq_done_o rise/fall together GAP+1 after that; rst_cause_o = 0 throughout.
- Button glitch: ext_rst_n_i[1] low for 10 cycles in RUN (DEBOUNCE = 16) → no change on any output. Held low for 30 cycles → all rst_o = 1 exactly 2 + 16 + 1 cycles after the press; rst_cause_o = 1; release restarts after the debounced release plus HOLD.
- Lock loss during RELEASE, after rst_o[0] has fallen → all rst_o = 1 and seq_done_o = 0 three cycles after pll_locked_i falls; rst_cause_o = 2; no release while lock stays low.
- Simultaneous dbg_rst_i and lock loss in RUN → rst_cause_o = 2. dbg_rst_i alone as a 1-cycle pulse → ASSERT; rst_cause_o = 3; full HOLD plus staged release follows.
- rst asserted for 1 cycle in RUN after a debug reset → rst_cause_o returns to 0, all rst_o = 1, and the full power-up sequence repeats.
- NUM_STAGE = 1 → rst_o[0] and seq_done_o change on the same edge, 2 + HOLD cycles after rst is released.
